// File: rtl/rnn_gate_unit.sv
// One RNN/LSTM gate: out = sigmoid(Wx*x + Wy*y + b), evaluated one weight column per cycle.
// Column-organised weight RAMs feed HIDDEN_SZ row accumulators, then a PLAN sigmoid stage.
module rnn_gate_unit #(
  parameter int INPUT_SZ      = 4,
  parameter int HIDDEN_SZ     = 32,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int DSP48_PER_ROW = 2,
  localparam int BW  = QN + QM + 1,
  localparam int LBW = BW * HIDDEN_SZ,
  localparam int AX  = $clog2(INPUT_SZ),
  localparam int AY  = $clog2(HIDDEN_SZ)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           beginCalc,
  input  logic [BW-1:0]  inputVec,
  input  logic [BW-1:0]  prevOutVec,
  input  logic [LBW-1:0] biasVec,
  input  logic [AX-1:0]  wrAddrX,
  input  logic           wrEnX,
  input  logic [LBW-1:0] wrDataX,
  input  logic [AY-1:0]  wrAddrY,
  input  logic           wrEnY,
  input  logic [LBW-1:0] wrDataY,
  output logic [AX-1:0]  colAddressRead_X,
  output logic [AY-1:0]  colAddressRead_Y,
  output logic           dataReady,
  output logic [LBW-1:0] gateOutput
);

  localparam int ACCW = 2 * BW + 8;
  localparam logic signed [ACCW-1:0] SatHi = ACCW'((1 << (BW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SatLo = -SatHi;
  localparam logic [BW-1:0] ActOne  = BW'(1 << QM);
  localparam logic [BW-1:0] ActHalf = BW'(1 << (QM - 1));
  localparam logic [BW-1:0] ThrFive = BW'(5 << QM);
  localparam logic [BW-1:0] ThrMid  = BW'((19 << QM) >> 3);
  localparam logic [BW-1:0] OffHigh = BW'((27 << QM) >> 5);
  localparam logic [BW-1:0] OffMid  = BW'((5 << QM) >> 3);

  typedef enum logic [1:0] {IDLE, RUN, ACT, DONE} state_t;

  state_t         state, stateNext;
  logic [AY-1:0]  colCount;
  logic           startRun;
  logic           lastCol;
  logic           useX;
  logic [LBW-1:0] colX, colY;
  logic [LBW-1:0] actVec;
  logic signed [BW-1:0] xVal, yVal;

  // Weight storage: writes are never gated by reset so weights can be loaded while held in reset.
  logic [LBW-1:0] ramX [INPUT_SZ];
  logic [LBW-1:0] ramY [HIDDEN_SZ];

  always_ff @(posedge clock) begin
    if (wrEnX) ramX[wrAddrX] <= wrDataX;
    if (wrEnY) ramY[wrAddrY] <= wrDataY;
  end

  assign colAddressRead_Y = colCount;
  assign colAddressRead_X = colCount[AX-1:0];
  assign colX = ramX[colAddressRead_X];
  assign colY = ramY[colAddressRead_Y];
  assign xVal = inputVec;
  assign yVal = prevOutVec;

  assign startRun = beginCalc && (state == IDLE || state == DONE);
  assign lastCol  = (colCount == AY'(HIDDEN_SZ - 1));
  assign useX     = (int'(colCount) < INPUT_SZ);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (beginCalc) stateNext = RUN;
      RUN:     if (lastCol)   stateNext = ACT;
      ACT:     stateNext = DONE;
      DONE:    if (beginCalc) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      colCount   <= '0;
      dataReady  <= 1'b0;
      gateOutput <= '0;
    end else begin
      state <= stateNext;
      if (startRun)          colCount <= '0;
      else if (state == RUN) colCount <= colCount + 1'b1;
      if (startRun) begin
        dataReady <= 1'b0;
      end else if (state == ACT) begin
        dataReady  <= 1'b1;
        gateOutput <= actVec;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HIDDEN_SZ; gi++) begin : g_row
      logic signed [BW-1:0]     wxR, wyR, biasR, preSat;
      logic signed [2*BW-1:0]   prodX, prodY, prodXg;
      logic signed [ACCW-1:0]   accR, preSum, preShift;
      logic [BW-1:0]            mag, fAct, actR;

      assign wxR   = colX[gi*BW +: BW];
      assign wyR   = colY[gi*BW +: BW];
      assign biasR = biasVec[gi*BW +: BW];

      // Both branches are arithmetically identical; the split only steers DSP packing.
      if (DSP48_PER_ROW >= 2) begin : g_parMul
        assign prodX = wxR * xVal;
        assign prodY = wyR * yVal;
      end else begin : g_narrowMul
        assign prodY = wyR * yVal;
        assign prodX = wxR * xVal;
      end
      assign prodXg = useX ? prodX : '0;

      always_ff @(posedge clock) begin
        if (reset || startRun) accR <= '0;
        else if (state == RUN)  accR <= accR + ACCW'(prodY) + ACCW'(prodXg);
      end

      always_comb begin
        preSum   = accR + (ACCW'(biasR) <<< QM);
        preShift = preSum >>> QM;
        if (preShift > SatHi)      preSat = SatHi[BW-1:0];
        else if (preShift < SatLo) preSat = SatLo[BW-1:0];
        else                       preSat = preShift[BW-1:0];
        mag = preSat[BW-1] ? BW'(-preSat) : BW'(preSat);
        if (mag >= ThrFive)     fAct = ActOne;
        else if (mag >= ThrMid) fAct = (mag >> 5) + OffHigh;
        else if (mag >= ActOne) fAct = (mag >> 3) + OffMid;
        else                    fAct = (mag >> 2) + ActHalf;
        actR = preSat[BW-1] ? ActOne - fAct : fAct;
      end

      assign actVec[gi*BW +: BW] = actR;
    end
  endgenerate

endmodule

// File: tb/tb_rnn_gate_unit.sv
// Randomized scoreboard bench for rnn_gate_unit against a plain-arithmetic gate model.
module tb_rnn_gate_unit;
  localparam int IN  = 4;
  localparam int HID = 32;
  localparam int QM  = 11;
  localparam int BW  = 18;
  localparam int LBW = BW * HID;
  localparam int AX  = 2;
  localparam int AY  = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           beginCalc = 1'b0;
  logic [BW-1:0]  inputVec, prevOutVec;
  logic [LBW-1:0] biasVec;
  logic [AX-1:0]  wrAddrX = '0;
  logic           wrEnX = 1'b0;
  logic [LBW-1:0] wrDataX = '0;
  logic [AY-1:0]  wrAddrY = '0;
  logic           wrEnY = 1'b0;
  logic [LBW-1:0] wrDataY = '0;
  logic [AX-1:0]  colAddressRead_X;
  logic [AY-1:0]  colAddressRead_Y;
  logic           dataReady;
  logic [LBW-1:0] gateOutput;

  rnn_gate_unit dut (
    .clock(clock), .reset(reset), .beginCalc(beginCalc),
    .inputVec(inputVec), .prevOutVec(prevOutVec), .biasVec(biasVec),
    .wrAddrX(wrAddrX), .wrEnX(wrEnX), .wrDataX(wrDataX),
    .wrAddrY(wrAddrY), .wrEnY(wrEnY), .wrDataY(wrDataY),
    .colAddressRead_X(colAddressRead_X), .colAddressRead_Y(colAddressRead_Y),
    .dataReady(dataReady), .gateOutput(gateOutput)
  );

  always #5 clock = ~clock;

  // Reference state: weights as matrices, vectors as plain integers.
  int wx [HID][IN];
  int wy [HID][HID];
  int biasV [HID];
  int xv [IN];
  int yv [HID];

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [LBW-1:0] sbQ [$];
  logic [LBW-1:0] expV;
  logic readyPrev = 1'b0;

  // Upstream vector store answers the presented addresses.
  always_comb begin
    inputVec   = xv[colAddressRead_X][BW-1:0];
    prevOutVec = yv[colAddressRead_Y][BW-1:0];
    biasVec    = '0;
    for (int r = 0; r < HID; r++) biasVec[r*BW +: BW] = biasV[r][BW-1:0];
  end

  function automatic longint planSigmoid(input longint pre);
    longint p, a, f;
    p = (pre > 131071) ? 131071 : ((pre < -131071) ? -131071 : pre);
    a = (p < 0) ? -p : p;
    if (a >= 5 * 2048)         f = 2048;
    else if (a * 8 >= 19 * 2048) f = a / 32 + 1728;
    else if (a >= 2048)        f = a / 8 + 1280;
    else                       f = a / 4 + 1024;
    return (p < 0) ? 2048 - f : f;
  endfunction

  function automatic logic [LBW-1:0] modelOut();
    logic [LBW-1:0] v;
    longint acc, pre, o;
    v = '0;
    for (int r = 0; r < HID; r++) begin
      acc = 0;
      for (int c = 0; c < IN; c++)  acc += longint'(wx[r][c]) * longint'(xv[c]);
      for (int c = 0; c < HID; c++) acc += longint'(wy[r][c]) * longint'(yv[c]);
      pre = (acc + longint'(biasV[r]) * 2048) >>> QM;
      o = planSigmoid(pre);
      v[r*BW +: BW] = o[BW-1:0];
    end
    return v;
  endfunction

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  task automatic fillAll(input int wxv, input int wyv, input int bv, input int xval, input int yval);
    for (int r = 0; r < HID; r++) begin
      for (int c = 0; c < IN; c++)  wx[r][c] = wxv;
      for (int c = 0; c < HID; c++) wy[r][c] = wyv;
      biasV[r] = bv;
    end
    for (int c = 0; c < IN; c++)  xv[c] = xval;
    for (int c = 0; c < HID; c++) yv[c] = yval;
  endtask

  task automatic loadWeights();
    for (int c = 0; c < IN; c++) begin
      @(negedge clock);
      wrEnX = 1'b1; wrAddrX = AX'(c);
      for (int r = 0; r < HID; r++) wrDataX[r*BW +: BW] = wx[r][c][BW-1:0];
    end
    @(negedge clock);
    wrEnX = 1'b0;
    for (int c = 0; c < HID; c++) begin
      wrEnY = 1'b1; wrAddrY = AY'(c);
      for (int r = 0; r < HID; r++) wrDataY[r*BW +: BW] = wy[r][c][BW-1:0];
      @(negedge clock);
    end
    wrEnY = 1'b0;
  endtask

  task automatic runCalc(input string name);
    int n;
    bit addrOk;
    sbQ.push_back(modelOut());
    @(negedge clock); beginCalc = 1'b1;
    @(negedge clock); beginCalc = 1'b0;
    n = 0; addrOk = 1'b1;
    while (!dataReady && n < 60) begin
      if (n < HID && (colAddressRead_Y !== AY'(n) || colAddressRead_X !== AX'(n % IN))) addrOk = 1'b0;
      @(negedge clock);
      n++;
    end
    checks++;
    if (!dataReady || n != HID + 1) begin
      errors++;
      $display("FAIL latency_%s got=%0d cycles (ready=%b) want=%0d", name, n, dataReady, HID + 1);
    end
    checks++;
    if (!addrOk) begin
      errors++;
      $display("FAIL addr_sweep_%s got=nonsequential want=Y 0..%0d X 0..%0d repeating", name, HID - 1, IN - 1);
    end
    $display("run %s latency=%0d", name, n);
  endtask

  // Monitor: every rising dataReady consumes one scoreboard entry.
  always @(negedge clock) begin
    if (dataReady && !readyPrev) begin
      txn++;
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got=row0 %0d want=no result", $signed(gateOutput[BW-1:0]));
      end else begin
        expV = sbQ.pop_front();
        if (gateOutput !== expV) begin
          errors++;
          for (int r = 0; r < HID; r++)
            if (gateOutput[r*BW +: BW] !== expV[r*BW +: BW]) begin
              $display("FAIL result_txn%0d row %0d got=%0d want=%0d", txn, r,
                       $signed(gateOutput[r*BW +: BW]), $signed(expV[r*BW +: BW]));
              break;
            end
        end else begin
          $display("txn %0d ok row0=%0d row4=%0d row31=%0d", txn, $signed(gateOutput[0 +: BW]),
                   $signed(gateOutput[4*BW +: BW]), $signed(gateOutput[31*BW +: BW]));
        end
      end
    end
    readyPrev <= dataReady;
  end

  initial begin
    bit sawReady;
    fillAll(0, 0, 0, 0, 0);
    loadWeights();               // loaded while reset is held
    @(negedge clock);
    checks++;
    if (dataReady !== 1'b0 || gateOutput !== '0 || colAddressRead_Y !== '0) begin
      errors++;
      $display("FAIL reset_state got=ready %b out_nonzero %b addrY %0d want=0 0 0",
               dataReady, gateOutput != '0, colAddressRead_Y);
    end
    reset = 1'b0;
    runCalc("zero");

    fillAll(2048, 0, 0, 2048, 0);
    loadWeights();
    runCalc("wx_one");

    fillAll(0, 0, -2048, 0, 0);
    loadWeights();
    runCalc("bias_neg");
    fillAll(0, 0, 2048, 0, 0);
    runCalc("bias_pos");

    fillAll(0, 16384, 0, 0, 16384);
    loadWeights();
    runCalc("sat_pos");
    fillAll(0, -16384, 0, 0, 16384);
    loadWeights();
    runCalc("sat_neg");

    fillAll(0, 0, 0, 0, 0);
    for (int r = 0; r < HID; r++) biasV[r] = r * 256;
    loadWeights();
    runCalc("bias_ramp");

    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < HID; r++) begin
        for (int c = 0; c < IN; c++)  wx[r][c] = (k < 2) ? rnd(1024) : rnd(131071);
        for (int c = 0; c < HID; c++) wy[r][c] = (k < 2) ? rnd(512) : rnd(131071);
        biasV[r] = rnd(12000);
      end
      for (int c = 0; c < IN; c++)  xv[c] = (k < 2) ? rnd(2048) : rnd(131071);
      for (int c = 0; c < HID; c++) yv[c] = (k < 2) ? rnd(1024) : rnd(131071);
      loadWeights();
      runCalc($sformatf("random%0d", k));
    end

    // Abort a run mid-way, then confirm weights survive the reset.
    fillAll(2048, 0, 0, 2048, 0);
    loadWeights();
    @(negedge clock); beginCalc = 1'b1;
    @(negedge clock); beginCalc = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (dataReady !== 1'b0 || gateOutput !== '0) begin
      errors++;
      $display("FAIL abort_clear got=ready %b out_nonzero %b want=0 0", dataReady, gateOutput != '0);
    end
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (dataReady) sawReady = 1'b1;
    end
    checks++;
    if (sawReady) begin
      errors++;
      $display("FAIL abort_no_ready got=dataReady pulse want=none");
    end
    $display("run abort done");
    runCalc("after_abort");

    repeat (3) @(negedge clock);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
